// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32I datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback,
// drives every datapath select and strobe, and runs the request/ready
// handshake to the shared instruction/data memory. Unsupported opcodes
// park the FSM in a sticky ILLEGAL state that only reset can leave.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] imm_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       retire,
   output logic       illegal_instr,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_ILLEGAL  = 4'd9
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;

   // Datapath select encodings
   localparam logic [1:0] IMM_I     = 2'b00;
   localparam logic [1:0] IMM_S     = 2'b01;
   localparam logic [1:0] SRCA_PC   = 2'b00;
   localparam logic [1:0] SRCA_RS1  = 2'b10;
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] RES_ALU   = 2'b00;
   localparam logic [1:0] RES_MEM   = 2'b01;

   state_t     r_state;
   state_t     w_next_state;

   logic       w_mem_req;
   logic       w_mem_write;
   logic       w_adr_src;
   logic       w_ir_write;
   logic       w_pc_write;
   logic       w_reg_write;
   logic [1:0] w_imm_src;
   logic [1:0] w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_alu_op;
   logic [1:0] w_result_src;
   logic       w_retire;
   logic       w_illegal;

   // State register; reset lands in FETCH immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and output decode (Mealy where strobes follow mem_ready)
   always_comb begin
      w_next_state = r_state;
      w_mem_req    = 1'b0;
      w_mem_write  = 1'b0;
      w_adr_src    = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_imm_src    = IMM_I;
      w_alu_src_a  = SRCA_PC;
      w_alu_src_b  = SRCB_RS2;
      w_alu_op     = ALU_ADD;
      w_result_src = RES_ALU;
      w_retire     = 1'b0;
      w_illegal    = 1'b0;

      case (r_state)
         S_FETCH: begin
            // Fetch from PC while the ALU computes PC+4; IR and PC load
            // on the cycle the memory completes the access.
            w_mem_req   = 1'b1;
            w_adr_src   = 1'b0;
            w_alu_src_a = SRCA_PC;
            w_alu_src_b = SRCB_FOUR;
            w_alu_op    = ALU_ADD;
            w_ir_write  = mem_ready;
            w_pc_write  = mem_ready;
            if (mem_ready) begin
               w_next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
               w_next_state = S_MEMADR;
            end else if (opcode == OP_RTYPE) begin
               w_next_state = S_EXECR;
            end else if (opcode == OP_ITYPE) begin
               w_next_state = S_EXECI;
            end else begin
               w_next_state = S_ILLEGAL;
            end
         end
         S_MEMADR: begin
            // Effective address = rs1 + immediate; immediate format
            // depends on load vs store.
            w_alu_src_a = SRCA_RS1;
            w_alu_src_b = SRCB_IMM;
            w_alu_op    = ALU_ADD;
            if (opcode == OP_STORE) begin
               w_imm_src    = IMM_S;
               w_next_state = S_MEMWRITE;
            end else begin
               w_imm_src    = IMM_I;
               w_next_state = S_MEMREAD;
            end
         end
         S_MEMREAD: begin
            w_mem_req = 1'b1;
            w_adr_src = 1'b1;
            if (mem_ready) begin
               w_next_state = S_MEMWB;
            end
         end
         S_MEMWB: begin
            w_result_src = RES_MEM;
            w_reg_write  = 1'b1;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
         end
         S_MEMWRITE: begin
            // Store retires on the cycle the write is accepted
            w_mem_req   = 1'b1;
            w_mem_write = 1'b1;
            w_adr_src   = 1'b1;
            w_retire    = mem_ready;
            if (mem_ready) begin
               w_next_state = S_FETCH;
            end
         end
         S_EXECR: begin
            w_alu_src_a  = SRCA_RS1;
            w_alu_src_b  = SRCB_RS2;
            w_alu_op     = ALU_FUNCT;
            w_next_state = S_ALUWB;
         end
         S_EXECI: begin
            w_alu_src_a  = SRCA_RS1;
            w_alu_src_b  = SRCB_IMM;
            w_imm_src    = IMM_I;
            w_alu_op     = ALU_FUNCT;
            w_next_state = S_ALUWB;
         end
         S_ALUWB: begin
            w_result_src = RES_ALU;
            w_reg_write  = 1'b1;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
         end
         S_ILLEGAL: begin
            // Trap is sticky; only reset leaves this state
            w_illegal    = 1'b1;
            w_next_state = S_ILLEGAL;
         end
         default: begin
            // Codes 10..15 are unreachable; recover to FETCH
            w_next_state = S_FETCH;
         end
      endcase

      // While reset is held the state is already FETCH, but the memory
      // request and the IR/PC load strobes must not escape.
      if (!rst_n) begin
         w_mem_req  = 1'b0;
         w_ir_write = 1'b0;
         w_pc_write = 1'b0;
      end
   end

   assign mem_req       = w_mem_req;
   assign mem_write     = w_mem_write;
   assign adr_src       = w_adr_src;
   assign ir_write      = w_ir_write;
   assign pc_write      = w_pc_write;
   assign reg_write     = w_reg_write;
   assign imm_src       = w_imm_src;
   assign alu_src_a     = w_alu_src_a;
   assign alu_src_b     = w_alu_src_b;
   assign alu_op        = w_alu_op;
   assign result_src    = w_result_src;
   assign retire        = w_retire;
   assign illegal_instr = w_illegal;
   assign state         = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks reset, R/I-type, load with
// wait states, store with a wait state, illegal trap and mid-access reset.
module tb_multicycle_ctrl;

   logic       clk;
   logic       rst_n;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_write;
   logic       adr_src;
   logic       ir_write;
   logic       pc_write;
   logic       reg_write;
   logic [1:0] imm_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] result_src;
   logic       retire;
   logic       illegal_instr;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   multicycle_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_write     (mem_write),
      .adr_src       (adr_src),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .reg_write     (reg_write),
      .imm_src       (imm_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .result_src    (result_src),
      .retire        (retire),
      .illegal_instr (illegal_instr),
      .state         (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-field comparison
   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full output-vector comparison:
   // {state, req, wr, adr, irw, pcw, rw, imm, srca, srcb, aluop, res, ret, ill}
   task automatic chkv(input string tag, input logic [3:0] st,
                       input logic req, input logic wr, input logic adr,
                       input logic irw, input logic pcw, input logic rw,
                       input logic [1:0] imm, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [1:0] aop,
                       input logic [1:0] rs, input logic ret, input logic ill);
      logic [21:0] obs;
      logic [21:0] exp;
      obs = {state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             imm_src, alu_src_a, alu_src_b, alu_op, result_src, retire, illegal_instr};
      exp = {st, req, wr, adr, irw, pcw, rw, imm, sa, sb, aop, rs, ret, ill};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
      end
   endtask

   // Advance one clock; drive inputs 2 units after the edge, sample 1 unit later
   task automatic next(input logic rdy, input logic [6:0] op);
      @(posedge clk);
      #2;
      mem_ready = rdy;
      opcode    = op;
      #1;
   endtask

   // Expected output vectors for fixed-output states
   task automatic exp_fetch(input string tag, input logic rdy);
      chkv(tag, 4'd0, 1, 0, 0, rdy, rdy, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
   endtask
   task automatic exp_decode(input string tag);
      chkv(tag, 4'd1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      opcode    = 7'd0;

      // Reset held, mem_ready high: no request or load strobes escape
      #3;
      chk("rst_state",    state,                   4'd0);
      chk("rst_mem_req",  {3'b0, mem_req},         4'd0);
      chk("rst_ir_write", {3'b0, ir_write},        4'd0);
      chk("rst_pc_write", {3'b0, pc_write},        4'd0);
      chk("rst_retire",   {3'b0, retire},          4'd0);
      chk("rst_illegal",  {3'b0, illegal_instr},   4'd0);
      @(posedge clk);
      #2;
      chk("rst_hold_state", state, 4'd0);

      // Release: first FETCH request in the same cycle, zero wait states
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      exp_fetch("rel_c1", 1'b1);

      // R-type: states 0,1,6,8 then FETCH
      next(1'b1, OP_RTYPE);
      exp_decode("r_decode");
      next(1'b1, OP_RTYPE);
      chkv("r_execr", 4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
      next(1'b1, OP_RTYPE);
      chkv("r_aluwb", 4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);

      // FETCH with one wait state, then completes
      next(1'b0, OP_RTYPE);
      exp_fetch("fetch_wait", 1'b0);
      next(1'b1, OP_RTYPE);
      exp_fetch("fetch_done", 1'b1);

      // I-type
      next(1'b0, OP_ITYPE);
      exp_decode("i_decode");
      next(1'b1, OP_ITYPE);
      chkv("i_execi", 4'd7, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0);
      next(1'b1, OP_ITYPE);
      chkv("i_aluwb", 4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);

      // Load with two wait states in MEMREAD: 0,1,2,3,3,3,4
      next(1'b1, OP_RTYPE);
      exp_fetch("ld_fetch", 1'b1);
      next(1'b1, OP_LOAD);
      exp_decode("ld_decode");
      next(1'b1, OP_LOAD);
      chkv("ld_memadr", 4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
      next(1'b0, OP_LOAD);
      chkv("ld_rd_w1", 4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      next(1'b0, OP_LOAD);
      chkv("ld_rd_w2", 4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      next(1'b1, OP_LOAD);
      chkv("ld_rd_ok", 4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      next(1'b1, OP_LOAD);
      chkv("ld_memwb", 4'd4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0);

      // Store with one wait state
      next(1'b1, OP_LOAD);
      exp_fetch("st_fetch", 1'b1);
      next(1'b0, OP_STORE);
      exp_decode("st_decode");
      next(1'b0, OP_STORE);
      chkv("st_memadr", 4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
      next(1'b0, OP_STORE);
      chkv("st_wr_w1", 4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      next(1'b1, OP_STORE);
      chkv("st_wr_ok", 4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
      next(1'b0, OP_STORE);
      exp_fetch("st_after", 1'b0);

      // Illegal opcode traps and sticks with mem_ready toggling
      next(1'b1, OP_STORE);
      exp_fetch("il_fetch", 1'b1);
      next(1'b1, OP_BRANCH);
      exp_decode("il_decode");
      for (int i = 0; i < 22; i++) begin
         next(i[0], OP_BRANCH);
         chkv("il_hold", 4'd9, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
      end

      // Reset pulse clears the trap
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk("il_rst_state", state, 4'd0);
      chk("il_rst_flag",  {3'b0, illegal_instr}, 4'd0);
      chk("il_rst_req",   {3'b0, mem_req}, 4'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      exp_fetch("il_rel_c1", 1'b1);
      next(1'b1, OP_LOAD);
      exp_decode("il_rel_c2");

      // Reset in the second MEMREAD wait cycle aborts the load
      next(1'b1, OP_LOAD);
      chkv("ab_memadr", 4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
      next(1'b0, OP_LOAD);
      chk("ab_w1_state", state, 4'd3);
      next(1'b0, OP_LOAD);
      chk("ab_w2_req", {3'b0, mem_req}, 4'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chkv("ab_rst", 4'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
      next(1'b1, OP_LOAD);
      chkv("ab_rst_hold", 4'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      exp_fetch("ab_rel_c1", 1'b1);
      next(1'b1, OP_RTYPE);
      exp_decode("ab_rel_c2");
      next(1'b1, OP_RTYPE);
      chk("ab_rel_execr", state, 4'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I datapath. Each instruction is sequenced through fetch, decode, execute, memory and writeback states. The block drives every datapath select and strobe, including `imm_src` to the sign extender (2'b00 I-type, 2'b01 S-type). It also handles a request/ready handshake to the shared instruction/data memory. Supported opcodes are loads, stores, R-type ALU and I-type ALU; any other opcode traps to a sticky illegal state.

## Interface
- No parameters.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `opcode` in 7: `instr[6:0]` from the instruction register; valid from DECODE onward.
- `mem_ready` in 1: memory completes the current access in this cycle.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: access is a write; valid only with `mem_req`.
- `adr_src` out 1: memory address select, 0 = PC, 1 = ALU result register.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: load the PC.
- `reg_write` out 1: register file write enable.
- `imm_src` out 2: 00 = I-type, 01 = S-type.
- `alu_src_a` out 2: 00 = PC, 01 = reserved, 10 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_op` out 2: 00 = add, 10 = funct3/funct7 decoded.
- `result_src` out 2: 00 = ALU output, 01 = memory read data.
- `retire` out 1: one-cycle pulse on the last cycle of an instruction.
- `illegal_instr` out 1: sticky trap flag.
- `state` out 4: current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, ILLEGAL=9. Codes 10–15 are unreachable; if entered, the next state is FETCH.
- All outputs are 0 in every state unless listed below.
- FETCH:
  - Outputs: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00.
  - `ir_write` = `pc_write` = `mem_ready` (Mealy).
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE: no strobes. Next state by `opcode`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - anything else → ILLEGAL
- MEMADR:
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00.
  - `imm_src`=00 if `opcode`=0000011, 01 if `opcode`=0100011.
  - Next state: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: `mem_req`=1, `adr_src`=1. Waits for `mem_ready`, then → MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, `retire`=1 → FETCH.
- MEMWRITE:
  - Outputs: `mem_req`=1, `mem_write`=1, `adr_src`=1.
  - `retire` = `mem_ready`.
  - Waits for `mem_ready`, then → FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10 → ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `imm_src`=00, `alu_op`=10 → ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, `retire`=1 → FETCH.
- ILLEGAL:
  - `illegal_instr`=1; all other strobes 0.
  - Remains in ILLEGAL until `rst_n` is asserted.

## Timing
- Reset:
  - `rst_n` low forces `state`=FETCH immediately.
  - While `rst_n` is low, `mem_req`, `ir_write` and `pc_write` are forced to 0. All other outputs are 0 as listed.
  - The first fetch request appears in the first cycle after `rst_n` deasserts.
- Reset asserted mid-access (MEMREAD, MEMWRITE, or FETCH wait): the request drops in the same cycle. No `retire`, `reg_write` or `pc_write` is issued for the aborted instruction.
- Handshake:
  - Once raised, `mem_req`, `mem_write` and `adr_src` are held stable until the cycle in which `mem_ready`=1.
  - `mem_ready` may be high in the first request cycle, giving zero wait states.
  - `mem_ready` outside a request state is ignored.
- Latency with zero wait states, counted from the first FETCH cycle to `retire` inclusive:
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Each memory wait cycle adds 1.
- `retire` is high for exactly one cycle per completed instruction. It is never asserted in ILLEGAL.
- `opcode` is sampled in DECODE and MEMADR only. The instruction register is stable in those states because `ir_write` is asserted only in FETCH.

## Test plan
- Reset release, `mem_ready` tied to 1:
  - Cycle 1: `state`=0, `mem_req`=1, `ir_write`=1, `pc_write`=1.
  - Cycle 2: `state`=1.
- R-type `opcode` 0110011, zero wait states: states 0,1,6,8. `reg_write`=1 and `retire`=1 in cycle 4; back in FETCH in cycle 5.
- Load `opcode` 0000011, with `mem_ready` low for 2 cycles in MEMREAD:
  - States 0,1,2,3,3,3,4.
  - `imm_src`=00 in MEMADR; `result_src`=01 in MEMWB; 7 cycles total.
- Store `opcode` 0100011, `mem_ready` low for 1 cycle:
  - `imm_src`=01 in MEMADR.
  - `mem_write`=1 and `adr_src`=1 held for 2 cycles; `retire` only on the ready cycle; `reg_write` never asserted.
- Illegal `opcode` 1100011 → ILLEGAL:
  - `illegal_instr`=1 held for 20+ cycles, with `mem_req`=0 throughout, even with `mem_ready` toggling.
  - A subsequent `rst_n` pulse clears it.
- `rst_n` asserted in the second MEMREAD wait cycle: `mem_req` goes to 0 in the same cycle, with no `retire`. After release, the block restarts in FETCH.
